// File: rtl/tick_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tick_ctrl                                                        |
// | Brief   : Rate-selectable enable tick plus debounced, tick-aligned reverse |
// |           request for the LED pattern shifter.                             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tick_ctrl #(
  parameter int                    NB_COUNTER      = 32,
  parameter logic [NB_COUNTER-1:0] R0              = NB_COUNTER'(2**26 - 1),
  parameter logic [NB_COUNTER-1:0] R1              = NB_COUNTER'(2**25 - 1),
  parameter logic [NB_COUNTER-1:0] R2              = NB_COUNTER'(2**24 - 1),
  parameter logic [NB_COUNTER-1:0] R3              = NB_COUNTER'(2**23 - 1),
  parameter int                    NB_DEBOUNCE     = 20,
  parameter int                    DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic [2:0] i_sw,
  input  logic       i_btn,
  output logic       o_valid,
  output logic       o_reverse
);

  localparam logic [NB_DEBOUNCE-1:0] c_DEB_LAST = NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);

  logic [NB_COUNTER-1:0]  r_count;
  logic [NB_DEBOUNCE-1:0] r_deb_count;
  logic                   r_valid;
  logic                   r_reverse;
  logic                   r_pending;
  logic                   r_sync_0;
  logic                   r_sync_1;
  logic                   r_stable;
  logic [NB_COUNTER-1:0]  w_lim;
  logic                   w_tick;
  logic                   w_rise;

  always_comb begin
    w_lim = R0;
    case (i_sw[2:1])
      2'b00:   w_lim = R0;
      2'b01:   w_lim = R1;
      2'b10:   w_lim = R2;
      default: w_lim = R3;
    endcase
  end

  // >= rather than == so a switch to a smaller limit fires on the next edge
  assign w_tick = i_sw[0] && (r_count >= w_lim);

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
      r_valid <= 1'b0;
    end else if (!i_sw[0]) begin
      r_count <= '0;
      r_valid <= 1'b0;
    end else if (w_tick) begin
      r_count <= '0;
      r_valid <= 1'b1;
    end else begin
      r_count <= r_count + NB_COUNTER'(1);
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_sync_0 <= 1'b0;
      r_sync_1 <= 1'b0;
    end else begin
      r_sync_0 <= i_btn;
      r_sync_1 <= r_sync_0;
    end
  end

  // Rise is the edge on which the stable level flips from 0 to 1
  assign w_rise = r_sync_1 && !r_stable && (r_deb_count == c_DEB_LAST);

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_deb_count <= '0;
      r_stable    <= 1'b0;
    end else if (r_sync_1 == r_stable) begin
      r_deb_count <= '0;
    end else if (r_deb_count == c_DEB_LAST) begin
      r_deb_count <= '0;
      r_stable    <= r_sync_1;
    end else begin
      r_deb_count <= r_deb_count + NB_DEBOUNCE'(1);
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_pending <= 1'b0;
      r_reverse <= 1'b0;
    end else if (w_tick) begin
      r_reverse <= r_pending | w_rise;
      r_pending <= 1'b0;
    end else begin
      r_reverse <= 1'b0;
      r_pending <= r_pending | w_rise;
    end
  end

  assign o_valid   = r_valid;
  assign o_reverse = r_reverse;

endmodule
`default_nettype wire

// File: tb/tb_tick_ctrl.sv
`default_nettype none
// Bench for tick_ctrl: cycle model feeding a scoreboard queue, a vector table
// for the reset/first-rate phase, and hand-written multi-cycle sequences.
module tb_tick_ctrl;

  localparam int DEB = 4;

  logic       clock;
  logic       i_reset;
  logic [2:0] i_sw;
  logic       i_btn;
  logic       o_valid;
  logic       o_reverse;

  tick_ctrl #(
    .NB_COUNTER     (32),
    .R0             (32'd3),
    .R1             (32'd7),
    .R2             (32'd15),
    .R3             (32'd31),
    .NB_DEBOUNCE    (3),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_sw     (i_sw),
    .i_btn    (i_btn),
    .o_valid  (o_valid),
    .o_reverse(o_reverse)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic v;
    logic r;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [2:0] sw;
    logic       btn;
    logic       ev;
    logic       er;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   rev_cnt  = 0;
  logic last_v   = 1'b0;
  logic last_r   = 1'b0;

  // Reference model state
  int   m_cnt    = 0;
  int   m_deb    = 0;
  logic m_s0     = 1'b0;
  logic m_s1     = 1'b0;
  logic m_stable = 1'b0;
  logic m_pend   = 1'b0;
  logic m_valid  = 1'b0;
  logic m_rev    = 1'b0;
  int   lims[4]  = '{3, 7, 15, 31};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_edge(input logic rst, input logic [2:0] sw, input logic btn);
    logic rise;
    logic tick;
    exp_t e;
    if (!rst) begin
      m_cnt = 0; m_deb = 0; m_s0 = 0; m_s1 = 0; m_stable = 0;
      m_pend = 0; m_valid = 0; m_rev = 0;
    end else begin
      rise = m_s1 && !m_stable && (m_deb == DEB - 1);
      tick = sw[0] && (m_cnt >= lims[sw[2:1]]);
      if (!sw[0]) begin
        m_cnt = 0; m_valid = 0; m_rev = 0; m_pend = m_pend | rise;
      end else if (tick) begin
        m_cnt = 0; m_valid = 1; m_rev = m_pend | rise; m_pend = 0;
      end else begin
        m_cnt++; m_valid = 0; m_rev = 0; m_pend = m_pend | rise;
      end
      if (m_s1 == m_stable) m_deb = 0;
      else if (m_deb == DEB - 1) begin
        m_stable = m_s1;
        m_deb    = 0;
      end else m_deb++;
      m_s1 = m_s0;
      m_s0 = btn;
    end
    e.v = m_valid;
    e.r = m_rev;
    sb.push_back(e);
  endtask

  task automatic step(input logic rst, input logic [2:0] sw, input logic btn);
    exp_t e;
    i_reset = rst;
    i_sw    = sw;
    i_btn   = btn;
    @(posedge clock);
    model_edge(rst, sw, btn);
    @(negedge clock);
    e = sb.pop_front();
    check("valid", int'(o_valid), int'(e.v));
    check("reverse", int'(o_reverse), int'(e.r));
    last_v = o_valid;
    last_r = o_reverse;
    if (o_reverse) rev_cnt++;
  endtask

  // Steps until o_valid is seen; n = cycles taken, r = o_reverse on that cycle
  task automatic wait_tick(input logic [2:0] sw, input logic btn, output int n, output logic r);
    n = 0;
    do begin
      step(1'b1, sw, btn);
      n++;
    end while (!last_v && n < 100);
    check("tick_seen", int'(last_v), 1);
    r = last_r;
  endtask

  vec_t vecs[15];
  int   n;
  logic r;

  initial begin
    i_reset = 1'b0;
    i_sw    = 3'b000;
    i_btn   = 1'b0;

    vecs = '{
      '{1'b0, 3'b001, 1'b0, 1'b0, 1'b0},
      '{1'b0, 3'b001, 1'b0, 1'b0, 1'b0},
      '{1'b0, 3'b001, 1'b0, 1'b0, 1'b0},
      '{1'b1, 3'b001, 1'b0, 1'b0, 1'b0},
      '{1'b1, 3'b001, 1'b0, 1'b0, 1'b0},
      '{1'b1, 3'b001, 1'b0, 1'b0, 1'b0},
      '{1'b1, 3'b001, 1'b0, 1'b1, 1'b0},
      '{1'b1, 3'b001, 1'b0, 1'b0, 1'b0},
      '{1'b1, 3'b001, 1'b0, 1'b0, 1'b0},
      '{1'b1, 3'b001, 1'b0, 1'b0, 1'b0},
      '{1'b1, 3'b001, 1'b0, 1'b1, 1'b0},
      '{1'b1, 3'b001, 1'b0, 1'b0, 1'b0},
      '{1'b1, 3'b001, 1'b0, 1'b0, 1'b0},
      '{1'b1, 3'b001, 1'b0, 1'b0, 1'b0},
      '{1'b1, 3'b001, 1'b0, 1'b1, 1'b0}
    };

    // Reset, then fastest-table rate (period 4)
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst, vecs[i].sw, vecs[i].btn);
      check("tbl_valid", int'(last_v), int'(vecs[i].ev));
      check("tbl_reverse", int'(last_r), int'(vecs[i].er));
    end

    // Period 32, then shrink the limit mid-count
    wait_tick(3'b111, 1'b0, n, r);
    check("period32_a", n, 32);
    wait_tick(3'b111, 1'b0, n, r);
    check("period32_b", n, 32);
    for (int k = 0; k < 20; k++) step(1'b1, 3'b111, 1'b0);
    step(1'b1, 3'b001, 1'b0);
    check("shrink_tick", int'(last_v), 1);
    wait_tick(3'b001, 1'b0, n, r);
    check("shrink_period", n, 4);

    // Clean press held 10 cycles
    wait_tick(3'b111, 1'b0, n, r);
    rev_cnt = 0;
    for (int k = 0; k < 10; k++) step(1'b1, 3'b111, 1'b1);
    check("press_no_early_rev", rev_cnt, 0);
    wait_tick(3'b111, 1'b0, n, r);
    check("press_tick_delay", n, 22);
    check("press_rev", int'(r), 1);
    wait_tick(3'b111, 1'b0, n, r);
    check("press_rev_once", int'(r), 0);

    // Bouncing button never qualifies
    rev_cnt = 0;
    for (int k = 0; k < 20; k++) step(1'b1, 3'b111, ((k / 2) % 2) == 0);
    for (int k = 0; k < 40; k++) step(1'b1, 3'b111, 1'b0);
    check("bounce_no_rev", rev_cnt, 0);

    // Two presses inside one period collapse into one request
    wait_tick(3'b111, 1'b0, n, r);
    rev_cnt = 0;
    for (int k = 0; k < 6; k++) step(1'b1, 3'b111, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b1, 3'b111, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b1, 3'b111, 1'b1);
    for (int k = 0; k < 8; k++) step(1'b1, 3'b111, 1'b0);
    wait_tick(3'b111, 1'b0, n, r);
    check("double_press_rev", int'(r), 1);
    check("double_press_count", rev_cnt, 1);

    // Pending survives a disable window
    wait_tick(3'b111, 1'b0, n, r);
    for (int k = 0; k < 7; k++) step(1'b1, 3'b111, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 3'b111, 1'b0);
    rev_cnt = 0;
    for (int k = 0; k < 10; k++) step(1'b1, 3'b110, 1'b0);
    check("disabled_no_rev", rev_cnt, 0);
    wait_tick(3'b111, 1'b0, n, r);
    check("reenable_period", n, 32);
    check("reenable_rev", int'(r), 1);

    // Asynchronous reset drops both outputs while they are high
    check("pre_drop_valid", int'(o_valid), 1);
    i_reset = 1'b0;
    #1;
    check("async_drop_valid", int'(o_valid), 0);
    check("async_drop_reverse", int'(o_reverse), 0);
    for (int k = 0; k < 3; k++) step(1'b0, 3'b111, 1'b0);
    wait_tick(3'b111, 1'b0, n, r);
    check("post_reset_period", n, 32);

    // Reset mid-count with a request pending discards everything
    for (int k = 0; k < 7; k++) step(1'b1, 3'b111, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 3'b111, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 3'b111, 1'b0);
    wait_tick(3'b111, 1'b0, n, r);
    check("midcount_reset_period", n, 32);
    check("midcount_reset_no_rev", int'(r), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
